range_window_sequencer: RTL

- Upstream stage of the range finder. Frames a raw, sparsely-valid sample stream into one measurement window.
- Drives the range finder's go/finish/data inputs so the protocol is never violated: no finish before go, no go while the finder is busy.
- Reports window completion so downstream logic can capture the range on the exact cycle it is final.

---
 rtl/range_window_pkg.sv | 15 +
 rtl/window_sample_counter.sv | 34 +++
 rtl/range_window_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/range_window_pkg.sv
// rtl/range_window_pkg.sv - shared types and constants for the range window sequencer
// Purpose: sequencer state encoding and the default range finder data width.
// Ports: none (package).
package range_window_pkg;

  localparam int DATA_W = 10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } state_t;

endpackage

// File: rtl/window_sample_counter.sv
// rtl/window_sample_counter.sv - saturating up-counter with clear, enable and terminal flag
// Purpose: counts enabled cycles up to MAX and holds there; clear has priority.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   clear          synchronous clear to 0
//   enable         count up by one (ignored once at MAX)
//   count          current count
//   terminal       high when the next enabled cycle reaches MAX (count == MAX-1)
module window_sample_counter #(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         terminal
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != W'(MAX))) begin
      count <= count + 1'b1;
    end
  end

  // Lets the owner act on the same edge that makes the count hit MAX.
  assign terminal = (count == W'(MAX - 1));

endmodule

// File: rtl/range_window_sequencer.sv
// rtl/range_window_sequencer.sv - frames a sparse sample stream into one range finder window
// Purpose: drives range finder go/finish/data without protocol violations and
//   flags window completion on the cycle the downstream range is final.
// Optional feature: define RANGE_WINDOW_TIMEOUT_EN to end a window after
//   TIMEOUT_CYCLES consecutive cycles without a sample while in RUN.
// Ports:
//   clock, reset           clock and asynchronous active-high reset
//   start                  request a new window (IDLE only)
//   abort                  end the current window early
//   sample_valid/data      raw sample stream
//   rf_go/rf_finish/rf_data registered range finder controls
//   busy                   not IDLE
//   window_done            one-cycle pulse, range value final this cycle
//   window_aborted         window ended by abort or timeout
//   sample_count           samples accepted in current/most recent window
module range_window_sequencer #(
  parameter int DATA_W         = range_window_pkg::DATA_W,
  parameter int WINDOW_LEN     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            sample_valid,
  input  logic [DATA_W-1:0]               sample_data,
  output logic                            rf_go,
  output logic                            rf_finish,
  output logic [DATA_W-1:0]               rf_data,
  output logic                            busy,
  output logic                            window_done,
  output logic                            window_aborted,
  output logic [$clog2(WINDOW_LEN+1)-1:0] sample_count
);

  import range_window_pkg::*;

  state_t            state, state_next;
  logic              go_next, finish_next, aborted_next;
  logic [DATA_W-1:0] data_next;
  logic              accept, clear_count;
  logic              count_terminal;
  logic              timeout;

  window_sample_counter #(
    .MAX (WINDOW_LEN)
  ) u_sample_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear_count),
    .enable   (accept),
    .count    (sample_count),
    .terminal (count_terminal)
  );

`ifdef RANGE_WINDOW_TIMEOUT_EN
  logic                              gap_terminal;
  logic [$clog2(TIMEOUT_CYCLES+1)-1:0] unused_gap_count;

  // Any accept or leaving RUN restarts the gap measurement.
  window_sample_counter #(
    .MAX (TIMEOUT_CYCLES)
  ) u_gap_counter (
    .clock    (clock),
    .reset    (reset),
    .clear    ((state != RUN) || sample_valid),
    .enable   ((state == RUN) && !sample_valid),
    .count    (unused_gap_count),
    .terminal (gap_terminal)
  );

  assign timeout = (state == RUN) && !sample_valid && gap_terminal;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    go_next      = 1'b0;
    finish_next  = 1'b0;
    data_next    = rf_data;
    aborted_next = window_aborted;
    accept       = 1'b0;
    clear_count  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next   = WAIT_FIRST;
          clear_count  = 1'b1;
          aborted_next = 1'b0;
        end
      end
      WAIT_FIRST: begin
        // No go has been issued yet, so an abort must not emit a finish.
        if (abort) begin
          state_next = IDLE;
        end else if (sample_valid) begin
          data_next  = sample_data;
          go_next    = 1'b1;
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // Early termination repeats the held sample, which cannot move min/max.
        if (abort || timeout) begin
          finish_next  = 1'b1;
          aborted_next = 1'b1;
          state_next   = DONE;
        end else if (sample_valid) begin
          data_next = sample_data;
          accept    = 1'b1;
          if (count_terminal) begin
            finish_next = 1'b1;
            state_next  = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_go          <= 1'b0;
      rf_finish      <= 1'b0;
      rf_data        <= '0;
      window_done    <= 1'b0;
      window_aborted <= 1'b0;
    end else begin
      rf_go          <= go_next;
      rf_finish      <= finish_next;
      rf_data        <= data_next;
      // The finder consumes finish one edge after it is driven, so done lags it.
      window_done    <= (state == DONE);
      window_aborted <= aborted_next;
    end
  end

  assign busy = (state != IDLE);

endmodule
